fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of (PC, instruction) entries held; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1: the IFU presents a fetched word this cycle.
REQ-005 The block SHALL have port in_pc, input, 32: PC of the presented word.
REQ-006 The block SHALL have port in_instr, input, 32: instruction word read at in_pc.
REQ-007 The block SHALL have port in_ready, output, 1: the queue accepts a word this cycle.
REQ-008 The block SHALL have port out_valid, output, 1: the head entry is valid for decode.
REQ-009 The block SHALL have port out_ready, input, 1: decode consumes the head this cycle.
REQ-010 The block SHALL have port out_pc, output, 32: PC of the head entry.
REQ-011 The block SHALL have port out_instr, output, 32: instruction of the head entry.
REQ-012 The block SHALL have port flush, input, 1: branch/jump redirect; discard all held entries.
REQ-013 The block SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 A push SHALL occur when in_valid and in_ready are both high at a rising edge and flush is low; the entry is written at the write pointer.
REQ-015 A pop SHALL occur when out_valid and out_ready are both high at a rising edge and flush is low; the read pointer advances.
REQ-016 in_ready SHALL equal (count != DEPTH); it SHALL NOT depend on out_ready, so a full queue never accepts a word, even when a pop happens in the same cycle.
REQ-017 out_valid SHALL equal (count != 0); there SHALL be no bypass, so a word pushed into an empty queue becomes visible one cycle later.
REQ-018 While out_valid is high, out_pc and out_instr SHALL show the entry at the read pointer; while it is low, both SHALL be 32'h00000000 (nop).
REQ-019 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and move both pointers.
REQ-020 The pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH with no extra cycle.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and hold otherwise; it SHALL never exceed DEPTH or drop below 0.
REQ-022 When flush is high at an edge, count and both pointers SHALL become 0, overriding any push or pop in that cycle; out_valid SHALL be low in the following cycle.
REQ-023 Storage contents SHALL be unchanged by flush; only the pointers and count define validity.
REQ-024 Entries SHALL leave the queue in exactly the order in which they were pushed.

Reset
REQ-025 While RESET is low, count, both pointers and all storage entries SHALL be 0, independent of clk.
REQ-026 Consequently, during and after reset: in_ready=1, out_valid=0, out_pc=0, out_instr=0, count=0.
REQ-027 If RESET is asserted mid-operation, all held entries SHALL be lost; the first push after reset release SHALL land in entry 0.

Structure
REQ-028 The DEPTH default and the NOP constant (32'h00000000) SHALL live in the shared constants header used by the pipeline stages.
REQ-029 Storage SHALL be one sub-module, fetch_queue_mem, with one write port and one asynchronous read port; pointer, count and flush control SHALL stay in fetch_queue.

Verification
REQ-030 Reset release, then push PCs 0x3000, 0x3004, 0x3008 with out_ready=0 -> count=3; out_pc=0x3000 from the cycle after the first push.
REQ-031 Fill to DEPTH=4, hold in_valid=1 and pulse out_ready=1 for one cycle -> in_ready stays 0 that cycle, count goes 4->3, and the 5th word is accepted only on the next cycle.
REQ-032 Push 6 words and pop continuously -> the pointers wrap, and the output PC sequence is 0x3000..0x3014 in order with no gaps or duplicates.
REQ-033 With count=2, assert flush together with in_valid and out_ready -> the next cycle gives count=0, out_valid=0, out_instr=0; a push after that reaches the head one cycle later.
REQ-034 Assert RESET low asynchronously between edges with count=3 -> count=0 and out_valid=0 immediately; after release, the first pushed word appears at out_pc.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the fetch/decode pipeline stages.
package fetch_queue_pkg;

    // Default number of (PC, instruction) entries held in the fetch queue.
    localparam int FQ_DEPTH_DEFAULT = 4;

    // Instruction and PC value presented to decode when nothing is valid.
    localparam logic [31:0] NOP = 32'h0000_0000;

    // One queue entry: the fetched word and the PC it was read from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: one synchronous write port, one asynchronous read port.
// Entries are cleared by reset; flush leaves them alone since validity is
// tracked entirely by the pointers and count in the parent.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            RESET,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  fq_entry_t       wr_data,
    input  logic [AW-1:0]   rd_addr,
    output fq_entry_t       rd_data
);

    fq_entry_t entries [DEPTH];

    // Write the addressed entry on a push; clear every entry while in reset.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_addr] <= wr_data;
        end
    end

    assign rd_data = entries[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the IFU and decode. Holds up to DEPTH fetched words in
// order. No bypass: a word pushed into an empty queue is visible one cycle
// later. in_ready is purely a function of occupancy, so a full queue refuses
// a word even in a cycle where decode pops. Flush discards all held entries.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic                      in_valid,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_instr,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_pc,
    output logic [31:0]               out_instr,
    input  logic                      flush,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    fq_entry_t     wr_entry;
    fq_entry_t     head;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);

    assign push = in_valid  && in_ready  && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_entry.pc    = in_pc;
    assign wr_entry.instr = in_instr;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .RESET   (RESET),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    // Decode sees NOP whenever the head is not valid.
    assign out_pc    = out_valid ? head.pc    : NOP;
    assign out_instr = out_valid ? head.instr : NOP;

    // Pointer and occupancy tracking; flush overrides any push or pop.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with DEPTH=4.
module tb_fetch_queue;

    logic        clk;
    logic        RESET;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0513};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        in_pc    = 32'h0;
        in_instr = 32'h0;
    endtask

    initial begin
        RESET     = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        drive_idle();

        // Reset state
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc",    out_pc,         32'h0);
        check("rst_out_instr", out_instr,      32'h0);
        check("rst_count",     32'(count),     32'd0);
        RESET = 1'b1;
        step();

        // Three pushes with decode stalled
        drive_push(32'h3000);
        check("empty_out_valid", 32'(out_valid), 32'd0);
        step();
        check("p1_count",     32'(count), 32'd1);
        check("p1_out_pc",    out_pc,     32'h3000);
        check("p1_out_instr", out_instr,  instr_of(32'h3000));
        drive_push(32'h3004);
        step();
        check("p2_out_pc", out_pc, 32'h3000);
        drive_push(32'h3008);
        step();
        check("p3_count",  32'(count), 32'd3);
        check("p3_out_pc", out_pc,      32'h3000);

        // Fill, then pop while full: the 5th word must wait one cycle
        drive_push(32'h300C);
        step();
        check("full_count",    32'(count),    32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive_push(32'h3010);
        out_ready = 1'b1;
        check("full_pop_in_ready", 32'(in_ready), 32'd0);
        step();
        check("full_pop_count",  32'(count), 32'd3);
        check("full_pop_out_pc", out_pc,     32'h3004);
        out_ready = 1'b0;
        step();
        check("fifth_count",  32'(count), 32'd4);
        check("fifth_out_pc", out_pc,     32'h3004);

        // Drain in order
        drive_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_out_pc", out_pc, 32'h3004 + 32'(4 * i));
            step();
        end
        check("drained_count",     32'(count),     32'd0);
        check("drained_out_valid", 32'(out_valid), 32'd0);
        check("drained_out_pc",    out_pc,         32'h0);

        // Six words streamed through with continuous pop; pointers wrap
        for (int i = 0; i < 6; i++) begin
            drive_push(32'h3000 + 32'(4 * i));
            step();
            check("stream_out_pc",    out_pc,     32'h3000 + 32'(4 * i));
            check("stream_out_instr", out_instr,  instr_of(32'h3000 + 32'(4 * i)));
            check("stream_count",     32'(count), 32'd1);
        end
        drive_idle();
        step();
        check("stream_end_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Flush with simultaneous push and pop request
        drive_push(32'h3100);
        step();
        drive_push(32'h3104);
        step();
        check("preflush_count", 32'(count), 32'd2);
        drive_push(32'h3108);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_count",     32'(count),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_instr", out_instr,      32'h0);
        check("flush_in_ready",  32'(in_ready),  32'd1);
        drive_push(32'h310C);
        step();
        check("postflush_count",     32'(count), 32'd1);
        check("postflush_out_pc",    out_pc,     32'h310C);
        check("postflush_out_instr", out_instr,  instr_of(32'h310C));
        drive_idle();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("postflush_drain", 32'(count), 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive_push(32'h3200 + 32'(4 * i));
            step();
        end
        drive_idle();
        check("prereset_count", 32'(count), 32'd3);
        #3;
        RESET = 1'b0;
        #1;
        check("async_rst_count",     32'(count),     32'd0);
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_pc",    out_pc,         32'h0);
        check("async_rst_in_ready",  32'(in_ready),  32'd1);
        step();
        check("held_rst_count", 32'(count), 32'd0);
        #2;
        RESET = 1'b1;
        step();
        drive_push(32'h3300);
        step();
        check("after_rst_out_pc", out_pc,     32'h3300);
        check("after_rst_count",  32'(count), 32'd1);
        drive_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
